// File: rtl/display_scan_controller.sv
// Digit-scan sequencer for a 4-digit multiplexed 7-segment display.
// Prescaled one-hot ring select, frame-synchronous double buffering and leading-zero blanking.
module display_scan_controller #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned PRESC_W = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       update,
    input  logic       blank_leading,
    input  logic [3:0] data_3,
    input  logic [3:0] data_2,
    input  logic [3:0] data_1,
    input  logic [3:0] data_0,
    output logic [3:0] ring_counter,
    output logic [3:0] digit_out,
    output logic       blank,
    output logic       frame_done
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         ring_q, ring_d;
    logic [15:0]        staging_q, staging_d;
    logic [15:0]        shown_q, shown_d;
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;

    logic        tick;
    logic        wrap;
    logic [15:0] data_in;
    logic        zero_3, zero_32, zero_321;

    assign data_in = {data_3, data_2, data_1, data_0};
    assign tick    = enable && (presc_q == PRESC_MAX);
    assign wrap    = tick && (ring_q == 4'b1000);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            ring_q       <= 4'b0001;
            staging_q    <= '0;
            shown_q      <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            ring_q       <= ring_d;
            staging_q    <= staging_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        presc_d      = presc_q;
        ring_d       = ring_q;
        staging_d    = staging_q;
        shown_d      = shown_q;
        pending_d    = pending_q;
        frame_done_d = wrap;

        if (!enable) begin
            presc_d = '0;
            ring_d  = 4'b0001;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (!$onehot(ring_q)) begin
                ring_d = 4'b0001;
            end else if (tick) begin
                ring_d = {ring_q[2:0], ring_q[3]};
            end
        end

        // An update landing on the wrap edge bypasses staging so the fresh value is shown at once.
        if (update) begin
            staging_d = data_in;
            if (wrap) begin
                shown_d   = data_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap && pending_q) begin
            shown_d   = staging_q;
            pending_d = 1'b0;
        end
    end

    assign zero_3   = (shown_q[15:12] == 4'd0);
    assign zero_32  = zero_3 && (shown_q[11:8] == 4'd0);
    assign zero_321 = zero_32 && (shown_q[7:4] == 4'd0);

    always_comb begin
        digit_out = shown_q[3:0];
        blank     = 1'b0;
        unique case (ring_q)
            4'b0010: begin
                digit_out = shown_q[7:4];
                blank     = zero_321;
            end
            4'b0100: begin
                digit_out = shown_q[11:8];
                blank     = zero_32;
            end
            4'b1000: begin
                digit_out = shown_q[15:12];
                blank     = zero_3;
            end
            default: begin
                digit_out = shown_q[3:0];
                blank     = 1'b0;
            end
        endcase
        blank = blank && blank_leading && enable;
    end

    assign ring_counter = enable ? ring_q : '0;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: slot-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_display_scan_controller;

    localparam int unsigned DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       update;
    logic       blank_leading;
    logic [3:0] data_3, data_2, data_1, data_0;
    logic [3:0] ring_counter;
    logic [3:0] digit_out;
    logic       blank;
    logic       frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit resync_req = 1'b0;

    display_scan_controller #(.CLK_DIV(DIV), .PRESC_W(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .update       (update),
        .blank_leading(blank_leading),
        .data_3       (data_3),
        .data_2       (data_2),
        .data_1       (data_1),
        .data_0       (data_0),
        .ring_counter (ring_counter),
        .digit_out    (digit_out),
        .blank        (blank),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    // Reference model: current digit index, cycles elapsed in the slot, and the two digit buffers.
    int         m_digit;
    int         m_cnt;
    logic [3:0] m_shown[4];
    logic [3:0] m_stage[4];
    bit         m_pending;
    bit         m_fd;

    always @(posedge clock or negedge reset_n) begin
        bit m_tick, m_wrap;
        if (!reset_n) begin
            m_digit = 0; m_cnt = 0; m_pending = 0; m_fd = 0;
            for (int k = 0; k < 4; k++) begin m_shown[k] = 4'd0; m_stage[k] = 4'd0; end
        end else begin
            m_tick = enable && (m_cnt == DIV - 1);
            m_wrap = m_tick && (m_digit == 3);
            if (!enable) begin
                m_cnt = 0; m_digit = 0;
            end else if (m_tick) begin
                m_cnt = 0; m_digit = (m_digit + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (update) begin
                m_stage[0] = data_0; m_stage[1] = data_1; m_stage[2] = data_2; m_stage[3] = data_3;
                if (m_wrap) begin
                    m_shown = m_stage;
                    m_pending = 0;
                end else begin
                    m_pending = 1;
                end
            end else if (m_wrap && m_pending) begin
                m_shown = m_stage;
                m_pending = 0;
            end
            m_fd = m_wrap;
            if (resync_req) m_digit = 0;
        end
    end

    function automatic logic exp_blank();
        logic all_zero = 1'b1;
        if (!enable || !blank_leading || m_digit == 0) return 1'b0;
        for (int k = m_digit; k < 4; k++) if (m_shown[k] != 4'd0) all_zero = 1'b0;
        return all_zero;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clock) begin
        #2;
        if (chk_en) begin
            check("model_ring", {12'd0, ring_counter}, {12'd0, enable ? (4'b0001 << m_digit) : 4'b0000});
            check("model_digit", {12'd0, digit_out}, {12'd0, m_shown[m_digit]});
            check("model_blank", {15'd0, blank}, {15'd0, exp_blank()});
            check("model_frame_done", {15'd0, frame_done}, {15'd0, m_fd});
        end
    end

    // Returns at the first negedge(+1) of a fresh slot whose select equals val.
    task automatic wait_slot(input logic [3:0] val);
        logic [3:0] prev;
        bit found = 1'b0;
        prev = ring_counter;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clock); #1;
            if (ring_counter == val && prev != val) found = 1'b1;
            prev = ring_counter;
        end
        if (!found) begin
            n_checks++;
            $display("FAIL slot_timeout: ring stayed %b, never entered %b", ring_counter, val);
        end
    endtask

    task automatic load(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        data_3 = d3; data_2 = d2; data_1 = d1; data_0 = d0;
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; update = 1'b0; blank_leading = 1'b0;
        data_3 = '0; data_2 = '0; data_1 = '0; data_0 = '0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ring", {12'd0, ring_counter}, 16'h0001);
        check("rst_digit", {12'd0, digit_out}, 16'h0000);
        check("rst_blank", {15'd0, blank}, 16'h0000);
        check("rst_frame_done", {15'd0, frame_done}, 16'h0000);
        chk_en = 1'b1;

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock); #1;
            if (i == 3) check("rst_ring_before_tick", {12'd0, ring_counter}, 16'h0001);
            if (i == 4) check("rst_first_rotation", {12'd0, ring_counter}, 16'h0002);
        end

        // Scan with 1,2,3,4
        load(4'd1, 4'd2, 4'd3, 4'd4);
        wait_slot(4'b0001);
        check("scan_digit0", {12'd0, digit_out}, 16'h0004);
        check("scan_frame_done_pulse", {15'd0, frame_done}, 16'h0001);
        @(negedge clock); #1;
        check("scan_frame_done_low", {15'd0, frame_done}, 16'h0000);
        wait_slot(4'b0010);
        check("scan_digit1", {12'd0, digit_out}, 16'h0003);
        repeat (40) @(negedge clock);

        // Tear-free update mid-frame
        wait_slot(4'b0100);
        load(4'd9, 4'd8, 4'd7, 4'd6);
        #1;
        check("tear_old_digit2", {12'd0, digit_out}, 16'h0002);
        wait_slot(4'b1000);
        check("tear_old_digit3", {12'd0, digit_out}, 16'h0001);
        wait_slot(4'b0001);
        check("tear_new_digit0", {12'd0, digit_out}, 16'h0006);
        wait_slot(4'b1000);
        check("tear_new_digit3", {12'd0, digit_out}, 16'h0009);

        // Update coinciding with the wrap tick
        wait_slot(4'b1000);
        repeat (3) @(negedge clock);
        load(4'd5, 4'd5, 4'd5, 4'd5);
        #1;
        check("simul_ring", {12'd0, ring_counter}, 16'h0001);
        check("simul_digit0", {12'd0, digit_out}, 16'h0005);
        check("simul_frame_done", {15'd0, frame_done}, 16'h0001);
        wait_slot(4'b1000);
        check("simul_digit3", {12'd0, digit_out}, 16'h0005);

        // Leading-zero blanking
        blank_leading = 1'b1;
        load(4'd0, 4'd0, 4'd7, 4'd0);
        wait_slot(4'b0001);
        check("lz_blank_d0", {15'd0, blank}, 16'h0000);
        wait_slot(4'b0010);
        check("lz_blank_d1", {15'd0, blank}, 16'h0000);
        check("lz_digit_d1", {12'd0, digit_out}, 16'h0007);
        wait_slot(4'b0100);
        check("lz_blank_d2", {15'd0, blank}, 16'h0001);
        wait_slot(4'b1000);
        check("lz_blank_d3", {15'd0, blank}, 16'h0001);
        load(4'd0, 4'd0, 4'd0, 4'd0);
        wait_slot(4'b0001);
        check("lz_all_zero_d0", {15'd0, blank}, 16'h0000);
        wait_slot(4'b0010);
        check("lz_all_zero_d1", {15'd0, blank}, 16'h0001);
        blank_leading = 1'b0;
        #1;
        check("lz_disabled", {15'd0, blank}, 16'h0000);

        // Enable low mid-frame, update while dark, then restart
        @(negedge clock);
        blank_leading = 1'b1;
        enable = 1'b0;
        #1;
        check("dis_ring_dark", {12'd0, ring_counter}, 16'h0000);
        check("dis_blank_low", {15'd0, blank}, 16'h0000);
        @(negedge clock);
        load(4'hA, 4'd0, 4'd0, 4'hF);
        repeat (4) @(negedge clock);
        #1;
        check("dis_ring_still_dark", {12'd0, ring_counter}, 16'h0000);
        enable = 1'b1;
        #1;
        check("reen_ring", {12'd0, ring_counter}, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock); #1;
            if (i == 3) check("reen_full_slot", {12'd0, ring_counter}, 16'h0001);
            if (i == 4) check("reen_rotation", {12'd0, ring_counter}, 16'h0002);
        end
        wait_slot(4'b0001);
        check("reen_pending_d0", {12'd0, digit_out}, 16'h000F);
        wait_slot(4'b1000);
        check("reen_pending_d3", {12'd0, digit_out}, 16'h000A);
        check("reen_nonzero_noblank", {15'd0, blank}, 16'h0000);

        // Corrupt the ring register and expect self-correction
        wait_slot(4'b0010);
        chk_en = 1'b0;
        force dut.ring_q = 4'b0110;
        #1;
        check("force_applied", {12'd0, ring_counter}, 16'h0006);
        @(negedge clock);
        release dut.ring_q;
        resync_req = 1'b1;
        @(negedge clock);
        #1;
        resync_req = 1'b0;
        check("ring_selfcorrect", {12'd0, ring_counter}, 16'h0001);
        chk_en = 1'b1;
        repeat (20) @(negedge clock);

        // Reset mid-frame
        wait_slot(4'b0100);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_ring", {12'd0, ring_counter}, 16'h0001);
        check("midrst_digit", {12'd0, digit_out}, 16'h0000);
        check("midrst_frame_done", {15'd0, frame_done}, 16'h0000);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock); #1;
            if (i == 3) check("midrst_before_tick", {12'd0, ring_counter}, 16'h0001);
            if (i == 4) check("midrst_first_rotation", {12'd0, ring_counter}, 16'h0002);
        end
        repeat (8) @(negedge clock);

        chk_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
